sdram_resp: RTL and testbench
=============================

# sdram_resp

Synthesizable single-rank SDRAM device responder for exercising the SDRAM controller in simulation and on FPGA loopback. It decodes controller commands on the SDR command bus, tracks open rows per bank, stores write bursts into an internal array, and returns read bursts after the programmed CAS latency. It sits on the device side of the controller, in place of the external SDRAM part.

## Interface
- BANK_BITS, 2, bank address width
- ROW_BITS, 4, row bits used (from addr LSBs)
- COL_BITS, 4, column bits used (from addr LSBs)
- DW, 16, data width
- clk  in  1  clock; all commands sampled on rising edge
- pwr_reset  in  1  asynchronous, active-high reset
- cs_n, ras_n, cas_n, we_n  in  1 each  command strobes
- ba  in  BANK_BITS  bank address
- addr  in  12  row/column/mode address; addr[10] = A10
- dq_in  in  DW  write data from controller
- dqm  in  DW/8  per-byte write mask, 1 = masked
- dq_out  out  DW  read data
- dq_oe  out  1  read data valid/drive enable
- err  out  1  sticky protocol error
- refresh_cnt  out  16  AUTO REFRESH commands seen, wraps

## Operation
- Commands (cs_n=0; ras_n,cas_n,we_n): 111 NOP, 011 ACTIVE, 101 READ, 100 WRITE, 010 PRECHARGE, 001 AUTO REFRESH, 000 LOAD MODE, 110 BURST TERMINATE. cs_n=1 → NOP.
- Per-bank state: IDLE / ACTIVE(row). ACTIVE on IDLE bank opens addr[ROW_BITS-1:0]; ACTIVE on ACTIVE bank → err, row replaced.
- PRECHARGE: A10=1 closes all banks, else bank ba. Precharge of IDLE bank legal, no effect.
- READ/WRITE to IDLE bank → err, command ignored. A10=1 → auto-precharge bank after burst's last word.
- AUTO REFRESH with any bank ACTIVE → err; refresh_cnt increments regardless.
- LOAD MODE: addr[2:0] burst length (0→1, 1→2, 2→4, 3→8; others → err, keep old); addr[6:4] CAS latency (2 or 3; others → err, keep old).
- Burst addressing: sequential, wrapping inside BL-aligned block (BL=4, start col 6 → 6,7,4,5).
- Write: word k written at edge of command + k; byte lanes with dqm=1 unchanged.
- New READ/WRITE during a burst truncates old burst and starts new one; BURST TERMINATE stops current burst (read words already in CAS pipeline still emerge).
- Array is not cleared by reset.

## Timing
- Reset values: dq_out=0, dq_oe=0, err=0, refresh_cnt=0, all banks IDLE, BL=1, CL=2, no burst active.
- READ sampled at edge n: word k stable on dq_out with dq_oe=1 for sampling at edge n+CL+k, k=0..BL-1; dq_oe=0 otherwise; dq_out=0 when dq_oe=0.
- READ issued while a WRITE burst in progress: write stops at edge n; read follows normal latency.
- WRITE at edge n while read data still in pipeline: pending read words from earlier commands still appear (controller's responsibility to avoid).
- Auto-precharge closes bank on the edge after last word written/issued.
- Reset mid-burst: outputs clear asynchronously; burst and pipeline discarded.
- err set one edge after offending command; cleared only by reset.

## Structure
- Package sdram_pkg: command encoding constants, mode field positions, BL/CL decode function, bank-state typedef.
- Sub-module sdram_read_pipe: CL-deep shift register (depth 3) carrying {valid, data}, drives dq_out/dq_oe.
- Array inferred as single-port RAM, 2^(BANK_BITS+ROW_BITS+COL_BITS) x DW, byte-enabled.

## Test plan
- Reset, LOAD MODE addr=0x022 (BL=4, CL=2), ACTIVE b1 row 3, WRITE b1 col 4 data A1..A4, READ b1 col 4 → A1..A4 at edges n+2..n+5, dq_oe high exactly 4 cycles.
- CL=3, BL=4, READ col 6 → words from cols 6,7,4,5 at n+3..n+6.
- WRITE with dqm=2'b10 on word 0 over 0xFFFF with 0x1234 → read back 0xFF34.
- READ to IDLE bank → err=1 next edge, dq_oe stays 0; AUTO REFRESH with bank open → err, refresh_cnt 0→1.
- BL=8 READ, BURST TERMINATE at n+2 → exactly 2 words output (CL=2); READ with A10=1 then READ same bank w/o ACTIVE → err.
- pwr_reset pulsed mid read burst → dq_oe=0 immediately; after release, re-ACTIVE and READ returns pre-reset written data.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM device responder: command encodings,
// mode-register field layout, bank/burst state types and mode decoders.
package sdram_pkg;

  typedef enum logic [2:0] {
    CMD_LMR = 3'b000,
    CMD_REF = 3'b001,
    CMD_PRE = 3'b010,
    CMD_ACT = 3'b011,
    CMD_WR  = 3'b100,
    CMD_RD  = 3'b101,
    CMD_BST = 3'b110,
    CMD_NOP = 3'b111
  } cmd_e;

  typedef enum logic {
    BANK_IDLE   = 1'b0,
    BANK_ACTIVE = 1'b1
  } bank_state_e;

  typedef enum logic [1:0] {
    BURST_IDLE  = 2'd0,
    BURST_READ  = 2'd1,
    BURST_WRITE = 2'd2
  } burst_e;

  localparam int A10_POS     = 10;
  localparam int MODE_BL_LSB = 0;
  localparam int MODE_CL_LSB = 4;

  localparam logic [3:0] BL_RESET = 4'd1;
  localparam logic [1:0] CL_RESET = 2'd2;
  localparam logic [1:0] CL_MAX   = 2'd3;

  // Returns {legal, burst length}; illegal codes return all zeros.
  function automatic logic [4:0] decode_bl(input logic [2:0] field);
    logic [4:0] res;
    case (field)
      3'd0:    res = {1'b1, 4'd1};
      3'd1:    res = {1'b1, 4'd2};
      3'd2:    res = {1'b1, 4'd4};
      3'd3:    res = {1'b1, 4'd8};
      default: res = 5'd0;
    endcase
    return res;
  endfunction

  // Returns {legal, CAS latency}; only 2 and 3 are supported.
  function automatic logic [2:0] decode_cl(input logic [2:0] field);
    logic [2:0] res;
    case (field)
      3'd2:    res = {1'b1, 2'd2};
      3'd3:    res = {1'b1, 2'd3};
      default: res = 3'd0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sdram_read_pipe.sv
// CAS-latency delay line for read data: two shift stages plus a registered
// output stage, tapped so data emerges CL edges after the word is issued.
module sdram_read_pipe
  import sdram_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          vld_i,
  input  logic [DW-1:0] dat_i,
  input  logic [1:0]    cl_i,
  output logic [DW-1:0] dq_o,
  output logic          oe_o
);

  logic [1:0]    vld_q;
  logic [DW-1:0] dat0_q;
  logic [DW-1:0] dat1_q;
  logic          tap_vld_s;
  logic [DW-1:0] tap_dat_s;

  // Select the stage feeding the output register from the programmed latency.
  always_comb begin
    if (cl_i == CL_MAX) begin
      tap_vld_s = vld_q[1];
      tap_dat_s = dat1_q;
    end else begin
      tap_vld_s = vld_q[0];
      tap_dat_s = dat0_q;
    end
  end

  // Shift stages and output register; idle slots carry zero data.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q  <= 2'b00;
      dat0_q <= '0;
      dat1_q <= '0;
      oe_o   <= 1'b0;
      dq_o   <= '0;
    end else begin
      vld_q  <= {vld_q[0], vld_i};
      dat0_q <= vld_i ? dat_i : '0;
      dat1_q <= dat0_q;
      oe_o   <= tap_vld_s;
      dq_o   <= tap_vld_s ? tap_dat_s : '0;
    end
  end

endmodule

// File: rtl/sdram_resp.sv
// Single-rank SDRAM device model: decodes the command bus, tracks open rows,
// stores write bursts and returns read bursts after the CAS latency.
module sdram_resp
  import sdram_pkg::*;
#(
  parameter int BANK_BITS = 2,
  parameter int ROW_BITS  = 4,
  parameter int COL_BITS  = 4,
  parameter int DW        = 16
) (
  input  logic                 clk,
  input  logic                 pwr_reset,
  input  logic                 cs_n,
  input  logic                 ras_n,
  input  logic                 cas_n,
  input  logic                 we_n,
  input  logic [BANK_BITS-1:0] ba,
  input  logic [11:0]          addr,
  input  logic [DW-1:0]        dq_in,
  input  logic [DW/8-1:0]      dqm,
  output logic [DW-1:0]        dq_out,
  output logic                 dq_oe,
  output logic                 err,
  output logic [15:0]          refresh_cnt
);

  localparam int NB    = 1 << BANK_BITS;
  localparam int AW    = BANK_BITS + ROW_BITS + COL_BITS;
  localparam int DEPTH = 1 << AW;
  localparam int NBYTE = DW / 8;

  bank_state_e          bank_st_q [NB];
  bank_state_e          bank_st_d [NB];
  logic [ROW_BITS-1:0]  row_q [NB];
  logic [ROW_BITS-1:0]  row_d [NB];
  burst_e               state_q, state_d;
  logic [BANK_BITS-1:0] b_bank_q, b_bank_d;
  logic [ROW_BITS-1:0]  b_row_q, b_row_d;
  logic [COL_BITS-1:0]  b_col_q, b_col_d;
  logic [3:0]           b_cnt_q, b_cnt_d;
  logic [3:0]           b_len_q, b_len_d;
  logic                 b_ap_q, b_ap_d;
  logic                 ap_pend_q, ap_pend_d;
  logic [BANK_BITS-1:0] ap_bank_q, ap_bank_d;
  logic [3:0]           bl_q, bl_d;
  logic [1:0]           cl_q, cl_d;
  logic                 err_q, err_d;
  logic [15:0]          ref_cnt_q, ref_cnt_d;

  cmd_e                 cmd_s;
  logic                 rw_ok_s;
  logic                 cont_s;
  logic                 any_open_s;
  logic                 err_evt_s;
  logic [4:0]           bl_dec_s;
  logic [2:0]           cl_dec_s;
  logic [AW-1:0]        mem_addr_s;
  logic                 mem_we_s;
  logic                 rd_vld_s;
  logic [DW-1:0]        rd_dat_s;
  logic                 unused_addr_s;

  logic [DW-1:0] mem [DEPTH];

  assign cmd_s         = cs_n ? CMD_NOP : cmd_e'({ras_n, cas_n, we_n});
  assign unused_addr_s = ^{addr[11], addr[9:7]};
  assign rd_dat_s      = mem[mem_addr_s];
  assign err           = err_q;
  assign refresh_cnt   = ref_cnt_q;

  // Sequential burst order wrapping inside the BL-aligned column block.
  function automatic logic [COL_BITS-1:0] col_wrap(input logic [COL_BITS-1:0] start,
                                                   input logic [3:0] k,
                                                   input logic [3:0] len);
    logic [COL_BITS-1:0] mask;
    mask = COL_BITS'(len - 4'd1);
    return (start & ~mask) | ((start + COL_BITS'(k)) & mask);
  endfunction

  // Command decode, bank tracking and burst sequencing.
  always_comb begin
    bank_st_d  = bank_st_q;
    row_d      = row_q;
    state_d    = state_q;
    b_bank_d   = b_bank_q;
    b_row_d    = b_row_q;
    b_col_d    = b_col_q;
    b_cnt_d    = b_cnt_q;
    b_len_d    = b_len_q;
    b_ap_d     = b_ap_q;
    ap_pend_d  = 1'b0;
    ap_bank_d  = ap_bank_q;
    bl_d       = bl_q;
    cl_d       = cl_q;
    ref_cnt_d  = ref_cnt_q;
    err_evt_s  = 1'b0;
    mem_addr_s = '0;
    mem_we_s   = 1'b0;
    rd_vld_s   = 1'b0;
    any_open_s = 1'b0;
    bl_dec_s   = decode_bl(addr[MODE_BL_LSB +: 3]);
    cl_dec_s   = decode_cl(addr[MODE_CL_LSB +: 3]);

    // A bank scheduled for auto-precharge closes before this edge's command is judged.
    if (ap_pend_q) begin
      bank_st_d[ap_bank_q] = BANK_IDLE;
    end else begin
      bank_st_d = bank_st_q;
    end
    for (int i = 0; i < NB; i++) begin
      any_open_s = any_open_s | (bank_st_d[i] == BANK_ACTIVE);
    end

    rw_ok_s = ((cmd_s == CMD_RD) || (cmd_s == CMD_WR)) && (bank_st_d[ba] == BANK_ACTIVE);
    cont_s  = (state_q != BURST_IDLE) && !rw_ok_s && (cmd_s != CMD_BST);

    if (cont_s) begin
      mem_addr_s = {b_bank_q, b_row_q, col_wrap(b_col_q, b_cnt_q, b_len_q)};
      mem_we_s   = (state_q == BURST_WRITE);
      rd_vld_s   = (state_q == BURST_READ);
      b_cnt_d    = b_cnt_q + 4'd1;
      if (b_cnt_q == (b_len_q - 4'd1)) begin
        state_d   = BURST_IDLE;
        ap_pend_d = b_ap_q;
        ap_bank_d = b_bank_q;
      end else begin
        state_d = state_q;
      end
    end else begin
      b_cnt_d = b_cnt_q;
    end

    case (cmd_s)
      CMD_ACT: begin
        err_evt_s     = (bank_st_d[ba] == BANK_ACTIVE);
        bank_st_d[ba] = BANK_ACTIVE;
        row_d[ba]     = addr[ROW_BITS-1:0];
      end
      CMD_PRE: begin
        if (addr[A10_POS]) begin
          for (int i = 0; i < NB; i++) begin
            bank_st_d[i] = BANK_IDLE;
          end
        end else begin
          bank_st_d[ba] = BANK_IDLE;
        end
      end
      CMD_RD, CMD_WR: begin
        err_evt_s = !rw_ok_s;
        if (rw_ok_s) begin
          mem_addr_s = {ba, row_q[ba], addr[COL_BITS-1:0]};
          mem_we_s   = (cmd_s == CMD_WR);
          rd_vld_s   = (cmd_s == CMD_RD);
          b_bank_d   = ba;
          b_row_d    = row_q[ba];
          b_col_d    = addr[COL_BITS-1:0];
          b_cnt_d    = 4'd1;
          b_len_d    = bl_q;
          b_ap_d     = addr[A10_POS];
          if (bl_q == 4'd1) begin
            state_d   = BURST_IDLE;
            ap_pend_d = addr[A10_POS];
            ap_bank_d = ba;
          end else begin
            state_d = (cmd_s == CMD_RD) ? BURST_READ : BURST_WRITE;
          end
        end else begin
          b_ap_d = b_ap_q;
        end
      end
      CMD_BST: begin
        state_d = BURST_IDLE;
      end
      CMD_REF: begin
        ref_cnt_d = ref_cnt_q + 16'd1;
        err_evt_s = any_open_s;
      end
      CMD_LMR: begin
        err_evt_s = !bl_dec_s[4] || !cl_dec_s[2];
        bl_d      = bl_dec_s[4] ? bl_dec_s[3:0] : bl_q;
        cl_d      = cl_dec_s[2] ? cl_dec_s[1:0] : cl_q;
      end
      default: begin
        err_evt_s = 1'b0;
      end
    endcase

    err_d = err_q | err_evt_s;
  end

  // Control state registers; the storage array is deliberately not reset.
  always_ff @(posedge clk or posedge pwr_reset) begin
    if (pwr_reset) begin
      for (int i = 0; i < NB; i++) begin
        bank_st_q[i] <= BANK_IDLE;
        row_q[i]     <= '0;
      end
      state_q   <= BURST_IDLE;
      b_bank_q  <= '0;
      b_row_q   <= '0;
      b_col_q   <= '0;
      b_cnt_q   <= 4'd0;
      b_len_q   <= 4'd0;
      b_ap_q    <= 1'b0;
      ap_pend_q <= 1'b0;
      ap_bank_q <= '0;
      bl_q      <= BL_RESET;
      cl_q      <= CL_RESET;
      err_q     <= 1'b0;
      ref_cnt_q <= 16'd0;
    end else begin
      bank_st_q <= bank_st_d;
      row_q     <= row_d;
      state_q   <= state_d;
      b_bank_q  <= b_bank_d;
      b_row_q   <= b_row_d;
      b_col_q   <= b_col_d;
      b_cnt_q   <= b_cnt_d;
      b_len_q   <= b_len_d;
      b_ap_q    <= b_ap_d;
      ap_pend_q <= ap_pend_d;
      ap_bank_q <= ap_bank_d;
      bl_q      <= bl_d;
      cl_q      <= cl_d;
      err_q     <= err_d;
      ref_cnt_q <= ref_cnt_d;
    end
  end

  // Byte-enabled write port of the storage array.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int i = 0; i < NBYTE; i++) begin
        if (!dqm[i]) begin
          mem[mem_addr_s][i*8 +: 8] <= dq_in[i*8 +: 8];
        end
      end
    end
  end

  sdram_read_pipe #(
    .DW(DW)
  ) u_read_pipe (
    .clk_i (clk),
    .rst_i (pwr_reset),
    .vld_i (rd_vld_s),
    .dat_i (rd_dat_s),
    .cl_i  (cl_q),
    .dq_o  (dq_out),
    .oe_o  (dq_oe)
  );

endmodule

// File: tb/tb_sdram_resp.sv
// Directed bench for sdram_resp: commands are driven one edge at a time and
// outputs are checked 1 time unit after each rising edge.
module tb_sdram_resp;

  localparam logic [2:0] C_NOP = 3'b111;
  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_RD  = 3'b101;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_PRE = 3'b010;
  localparam logic [2:0] C_REF = 3'b001;
  localparam logic [2:0] C_LMR = 3'b000;
  localparam logic [2:0] C_BST = 3'b110;

  logic        clk;
  logic        pwr_reset;
  logic        cs_n, ras_n, cas_n, we_n;
  logic [1:0]  ba;
  logic [11:0] addr;
  logic [15:0] dq_in;
  logic [1:0]  dqm;
  logic [15:0] dq_out;
  logic        dq_oe;
  logic        err;
  logic [15:0] refresh_cnt;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_a [4];
  logic [15:0] exp_w [4];

  sdram_resp dut (
    .clk         (clk),
    .pwr_reset   (pwr_reset),
    .cs_n        (cs_n),
    .ras_n       (ras_n),
    .cas_n       (cas_n),
    .we_n        (we_n),
    .ba          (ba),
    .addr        (addr),
    .dq_in       (dq_in),
    .dqm         (dqm),
    .dq_out      (dq_out),
    .dq_oe       (dq_oe),
    .err         (err),
    .refresh_cnt (refresh_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] c, input logic [1:0] b, input logic [11:0] a,
                       input logic [15:0] d, input logic [1:0] m);
    cs_n = 1'b0;
    {ras_n, cas_n, we_n} = c;
    ba = b;
    addr = a;
    dq_in = d;
    dqm = m;
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    issue(C_NOP, 2'd0, 12'h000, 16'h0000, 2'b00);
  endtask

  task automatic rst_pulse();
    cs_n = 1'b1;
    pwr_reset = 1'b1;
    @(posedge clk);
    #1;
    pwr_reset = 1'b0;
  endtask

  initial begin
    pwr_reset = 1'b1;
    cs_n = 1'b1; ras_n = 1'b1; cas_n = 1'b1; we_n = 1'b1;
    ba = 2'd0; addr = 12'h000; dq_in = 16'h0000; dqm = 2'b00;
    exp_a = '{16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4};
    exp_w = '{16'h00A3, 16'h00A4, 16'h00A1, 16'h00A2};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dq_out", {16'd0, dq_out}, 32'h0);
    chk("rst_dq_oe", {31'd0, dq_oe}, 32'h0);
    chk("rst_err", {31'd0, err}, 32'h0);
    chk("rst_refcnt", {16'd0, refresh_cnt}, 32'h0);
    pwr_reset = 1'b0;

    // Default mode BL=1, CL=2
    issue(C_ACT, 2'd0, 12'h000, 16'h0000, 2'b00);
    issue(C_WR, 2'd0, 12'h000, 16'h5555, 2'b00);
    issue(C_RD, 2'd0, 12'h000, 16'h0000, 2'b00);
    chk("bl1_early_oe", {31'd0, dq_oe}, 32'h0);
    nop();
    chk("bl1_word_oe", {31'd0, dq_oe}, 32'h1);
    chk("bl1_word", {16'd0, dq_out}, 32'h5555);
    nop();
    chk("bl1_after_oe", {31'd0, dq_oe}, 32'h0);
    chk("bl1_after_dq", {16'd0, dq_out}, 32'h0);
    issue(C_PRE, 2'd0, 12'h400, 16'h0000, 2'b00);

    // BL=4 CL=2 write then read
    issue(C_LMR, 2'd0, 12'h022, 16'h0000, 2'b00);
    issue(C_ACT, 2'd1, 12'h003, 16'h0000, 2'b00);
    issue(C_WR, 2'd1, 12'h004, exp_a[0], 2'b00);
    for (int k = 1; k < 4; k++) issue(C_NOP, 2'd0, 12'h000, exp_a[k], 2'b00);
    issue(C_RD, 2'd1, 12'h004, 16'h0000, 2'b00);
    chk("bl4_lat_oe", {31'd0, dq_oe}, 32'h0);
    for (int k = 0; k < 4; k++) begin
      nop();
      chk("bl4_oe", {31'd0, dq_oe}, 32'h1);
      chk("bl4_word", {16'd0, dq_out}, {16'd0, exp_a[k]});
    end
    nop();
    chk("bl4_end_oe", {31'd0, dq_oe}, 32'h0);
    chk("bl4_end_dq", {16'd0, dq_out}, 32'h0);

    // BL=4 CL=3 wrapped read from column 6
    issue(C_LMR, 2'd0, 12'h032, 16'h0000, 2'b00);
    issue(C_RD, 2'd1, 12'h006, 16'h0000, 2'b00);
    nop();
    chk("cl3_lat_oe", {31'd0, dq_oe}, 32'h0);
    for (int k = 0; k < 4; k++) begin
      nop();
      chk("cl3_oe", {31'd0, dq_oe}, 32'h1);
      chk("cl3_wrap_word", {16'd0, dq_out}, {16'd0, exp_w[k]});
    end
    nop();
    chk("cl3_end_oe", {31'd0, dq_oe}, 32'h0);

    // Byte mask on write
    issue(C_LMR, 2'd0, 12'h020, 16'h0000, 2'b00);
    issue(C_WR, 2'd1, 12'h000, 16'hFFFF, 2'b00);
    issue(C_WR, 2'd1, 12'h000, 16'h1234, 2'b10);
    issue(C_RD, 2'd1, 12'h000, 16'h0000, 2'b00);
    nop();
    chk("dqm_word", {16'd0, dq_out}, 32'hFF34);

    // READ to idle bank
    chk("err_clean", {31'd0, err}, 32'h0);
    issue(C_RD, 2'd2, 12'h000, 16'h0000, 2'b00);
    chk("err_rd_idle", {31'd0, err}, 32'h1);
    nop();
    chk("rd_idle_oe1", {31'd0, dq_oe}, 32'h0);
    nop();
    chk("rd_idle_oe2", {31'd0, dq_oe}, 32'h0);

    // AUTO REFRESH with an open bank, then with all closed
    rst_pulse();
    chk("rst2_err", {31'd0, err}, 32'h0);
    issue(C_ACT, 2'd0, 12'h000, 16'h0000, 2'b00);
    chk("act_ok_err", {31'd0, err}, 32'h0);
    issue(C_REF, 2'd0, 12'h000, 16'h0000, 2'b00);
    chk("ref_cnt1", {16'd0, refresh_cnt}, 32'h1);
    chk("ref_open_err", {31'd0, err}, 32'h1);
    issue(C_PRE, 2'd0, 12'h400, 16'h0000, 2'b00);
    issue(C_REF, 2'd0, 12'h000, 16'h0000, 2'b00);
    chk("ref_cnt2", {16'd0, refresh_cnt}, 32'h2);

    // BL=8 read cut by BURST TERMINATE
    rst_pulse();
    issue(C_LMR, 2'd0, 12'h023, 16'h0000, 2'b00);
    issue(C_ACT, 2'd2, 12'h005, 16'h0000, 2'b00);
    issue(C_WR, 2'd2, 12'h000, 16'h0B00, 2'b00);
    for (int k = 1; k < 8; k++) issue(C_NOP, 2'd0, 12'h000, 16'h0B00 + 16'(k), 2'b00);
    issue(C_RD, 2'd2, 12'h000, 16'h0000, 2'b00);
    nop();
    chk("bst_w0", {15'd0, dq_oe, dq_out}, {15'd0, 1'b1, 16'h0B00});
    issue(C_BST, 2'd0, 12'h000, 16'h0000, 2'b00);
    chk("bst_w1", {15'd0, dq_oe, dq_out}, {15'd0, 1'b1, 16'h0B01});
    nop();
    chk("bst_stop1", {31'd0, dq_oe}, 32'h0);
    nop();
    chk("bst_stop2", {31'd0, dq_oe}, 32'h0);

    // Auto-precharge read, then READ without ACTIVE
    issue(C_RD, 2'd2, 12'h400, 16'h0000, 2'b00);
    nop();
    chk("ap_w0", {16'd0, dq_out}, 32'h0B00);
    repeat (10) nop();
    chk("ap_no_err", {31'd0, err}, 32'h0);
    chk("ap_done_oe", {31'd0, dq_oe}, 32'h0);
    issue(C_RD, 2'd2, 12'h000, 16'h0000, 2'b00);
    chk("ap_closed_err", {31'd0, err}, 32'h1);
    nop();
    nop();
    chk("ap_closed_oe", {31'd0, dq_oe}, 32'h0);

    // Reset in the middle of a read burst
    issue(C_ACT, 2'd2, 12'h005, 16'h0000, 2'b00);
    issue(C_RD, 2'd2, 12'h000, 16'h0000, 2'b00);
    nop();
    nop();
    chk("mid_w1", {15'd0, dq_oe, dq_out}, {15'd0, 1'b1, 16'h0B01});
    #2;
    pwr_reset = 1'b1;
    cs_n = 1'b1;
    #1;
    chk("async_oe", {31'd0, dq_oe}, 32'h0);
    chk("async_dq", {16'd0, dq_out}, 32'h0);
    chk("async_err", {31'd0, err}, 32'h0);
    @(posedge clk);
    #1;
    pwr_reset = 1'b0;
    nop();
    chk("post_rst_oe", {31'd0, dq_oe}, 32'h0);
    issue(C_ACT, 2'd2, 12'h005, 16'h0000, 2'b00);
    issue(C_RD, 2'd2, 12'h003, 16'h0000, 2'b00);
    nop();
    chk("keep_b2", {15'd0, dq_oe, dq_out}, {15'd0, 1'b1, 16'h0B03});
    issue(C_ACT, 2'd1, 12'h003, 16'h0000, 2'b00);
    issue(C_RD, 2'd1, 12'h000, 16'h0000, 2'b00);
    nop();
    chk("keep_b1", {15'd0, dq_oe, dq_out}, {15'd0, 1'b1, 16'hFF34});
    chk("final_err", {31'd0, err}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
